strhw_msg_sequencer: RTL and testbench

//   Feeds an arbitrary-length message, streamed as 64-bit words, into strhw_control_logic. Packs words

---
 rtl/strhw_msg_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_strhw_msg_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strhw_msg_sequencer.sv
// Message sequencer: packs 64-bit message words into 512-bit blocks and drives the hash core handshake.
// Latency: a block is offered to the core one cycle after it closes; the hash appears one cycle after core DONE.
// Backpressure: s_ready_o is high only while filling a block; the result is held until m_hash_ready_i.
//
// Ports:
//   clk_i / rst_i                                clock, asynchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o/s_last_i        message word stream (byte b at [8b+7:8b])
//   s_bytes_i, s_hash_size_i                     valid bytes of last word; hash size (taken on first word)
//   m_hash_o/m_hash_size_o/m_hash_valid_o/_ready result port
//   core_*                                       strhw_control_logic trg/state handshake and data
//   error_o                                      sticky watchdog error

package strhw_msg_sequencer_pkg;
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

module strhw_msg_sequencer
    import strhw_msg_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [63:0]  s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic         s_last_i,
    input  logic [3:0]   s_bytes_i,
    input  logic         s_hash_size_i,
    output logic [511:0] m_hash_o,
    output logic         m_hash_size_o,
    output logic         m_hash_valid_o,
    input  logic         m_hash_ready_i,
    input  state_t       core_state_i,
    output logic         core_trg_o,
    output logic [511:0] core_block_o,
    output logic [6:0]   core_block_size_o,
    output logic         core_hash_size_o,
    input  logic [511:0] core_hash_i,
    output logic         error_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LP_TIMEOUT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LP_CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_INIT, S_FILL, S_DISP_WAIT, S_DISP_TRG, S_WAIT_DONE, S_RELEASE, S_HOLD, S_ERROR
    } fsm_t;

    fsm_t           r_state, w_state_nxt;
    logic [2:0]     r_word_cnt;
    logic [511:0]   r_block;
    logic [6:0]     r_size;
    logic           r_pend_zero;
    logic           r_first;
    logic           r_hash_size;
    logic           r_trg, w_trg_nxt;
    logic           r_ready;
    logic [511:0]   r_hash;
    logic           r_hash_vld, w_vld_nxt;
    logic           r_m_hash_size;
    logic           r_error;
    logic [CW-1:0]  r_wait_cnt;

    logic           w_accept;
    logic           w_close;
    logic [3:0]     w_bytes_eff;
    logic [63:0]    w_word_masked;
    logic [6:0]     w_size_acc;
    logic           w_wait_state;
    logic           w_timeout;
    logic           w_clr_block;
    logic           w_zero_dispatch;
    logic           w_capture;

    // r_ready is only ever set while the FSM is in FILL, so it doubles as the accept qualifier.
    assign w_accept    = s_valid_i & r_ready;
    assign w_close     = w_accept & (s_last_i | (r_word_cnt == 3'd7));
    // Non-last words always carry 8 bytes; out-of-range byte counts are clamped to a full word.
    assign w_bytes_eff = (s_last_i && (s_bytes_i < 4'd8)) ? s_bytes_i : 4'd8;
    assign w_size_acc  = {1'b0, r_word_cnt, 3'b000} + {3'b000, w_bytes_eff};

    always_comb begin
        w_word_masked = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < w_bytes_eff) begin
                w_word_masked[8*j +: 8] = s_data_i[8*j +: 8];
            end
        end
    end

    assign w_wait_state = (r_state == S_INIT)      || (r_state == S_DISP_WAIT) ||
                          (r_state == S_DISP_TRG)  || (r_state == S_WAIT_DONE) ||
                          (r_state == S_RELEASE);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_wait_state && (r_wait_cnt == LP_TIMEOUT);

    // Next-state and control decode
    always_comb begin
        w_state_nxt     = r_state;
        w_trg_nxt       = r_trg;
        w_vld_nxt       = r_hash_vld;
        w_clr_block     = 1'b0;
        w_zero_dispatch = 1'b0;
        w_capture       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_ERROR;
            w_trg_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (core_state_i == CLEAR) w_state_nxt = S_FILL;
                end
                S_FILL: begin
                    if (w_close) w_state_nxt = S_DISP_WAIT;
                end
                S_DISP_WAIT: begin
                    if ((core_state_i == CLEAR) || (core_state_i == READY)) begin
                        w_trg_nxt   = 1'b1;
                        w_state_nxt = S_DISP_TRG;
                    end
                end
                S_DISP_TRG: begin
                    if (core_state_i == BUSY) begin
                        w_trg_nxt   = 1'b0;
                        w_clr_block = 1'b1;
                        if (r_size < 7'd64) begin
                            w_state_nxt = S_WAIT_DONE;
                        end else if (r_pend_zero) begin
                            // Message was an exact multiple of 64 bytes: follow with an empty block.
                            w_zero_dispatch = 1'b1;
                            w_state_nxt     = S_DISP_WAIT;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (core_state_i == DONE) begin
                        w_capture   = 1'b1;
                        w_vld_nxt   = 1'b1;
                        w_trg_nxt   = 1'b1;
                        w_state_nxt = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_hash_vld && m_hash_ready_i) w_vld_nxt = 1'b0;
                    if (core_state_i == CLEAR) begin
                        w_trg_nxt   = 1'b0;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!r_hash_vld) begin
                        w_state_nxt = S_FILL;
                    end else if (m_hash_ready_i) begin
                        w_vld_nxt   = 1'b0;
                        w_state_nxt = S_FILL;
                    end
                end
                S_ERROR: begin
                    w_trg_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_ERROR;
                    w_trg_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_INIT;
            r_trg      <= 1'b0;
            r_hash_vld <= 1'b0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_trg      <= w_trg_nxt;
            r_hash_vld <= w_vld_nxt;
            r_ready    <= (w_state_nxt == S_FILL);
            r_error    <= r_error | (w_state_nxt == S_ERROR);
            // Restarts on every state change, so each wait state begins counting from zero.
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != LP_CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // Block assembly, sizing and result capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word_cnt    <= '0;
            r_block       <= '0;
            r_size        <= '0;
            r_pend_zero   <= 1'b0;
            r_first       <= 1'b1;
            r_hash_size   <= 1'b0;
            r_hash        <= '0;
            r_m_hash_size <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_word_cnt == 3'd0) begin
                    r_block <= {448'b0, w_word_masked};
                end else begin
                    r_block[{r_word_cnt, 6'b000000} +: 64] <= w_word_masked;
                end
                r_word_cnt <= w_close ? 3'd0 : r_word_cnt + 3'd1;
                r_size     <= w_size_acc;
                if (r_first) begin
                    r_hash_size <= s_hash_size_i;
                    r_first     <= 1'b0;
                end
                if (w_close && s_last_i && (r_word_cnt == 3'd7) && (w_size_acc == 7'd64)) begin
                    r_pend_zero <= 1'b1;
                end
            end
            if (w_clr_block) r_block <= '0;
            if (w_zero_dispatch) begin
                r_size      <= '0;
                r_pend_zero <= 1'b0;
            end
            if (w_capture) begin
                r_hash        <= core_hash_i;
                r_m_hash_size <= r_hash_size;
            end
            if ((r_state == S_HOLD) && (w_state_nxt == S_FILL)) r_first <= 1'b1;
        end
    end

    assign s_ready_o         = r_ready;
    assign m_hash_o          = r_hash;
    assign m_hash_size_o     = r_m_hash_size;
    assign m_hash_valid_o    = r_hash_vld;
    assign core_trg_o        = r_trg;
    assign core_block_o      = r_block;
    assign core_block_size_o = r_size;
    assign core_hash_size_o  = r_hash_size;
    assign error_o           = r_error;

endmodule

// File: tb/tb_strhw_msg_sequencer.sv
`timescale 1ns/1ps
module tb_strhw_msg_sequencer;
    import strhw_msg_sequencer_pkg::*;

    localparam int TO = 16;
    localparam logic [511:0] IV = {8{64'h6a09e667f3bcc908}};

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [63:0]  s_data_i = '0;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic         s_last_i = 1'b0;
    logic [3:0]   s_bytes_i = '0;
    logic         s_hash_size_i = 1'b0;
    logic [511:0] m_hash_o;
    logic         m_hash_size_o;
    logic         m_hash_valid_o;
    logic         m_hash_ready_i = 1'b0;
    state_t       core_st;
    logic         core_trg_o;
    logic [511:0] core_block_o;
    logic [6:0]   core_block_size_o;
    logic         core_hash_size_o;
    logic [511:0] core_h;
    logic         error_o;

    always #5 clk_i = ~clk_i;

    strhw_msg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_last_i(s_last_i), .s_bytes_i(s_bytes_i), .s_hash_size_i(s_hash_size_i),
        .m_hash_o(m_hash_o), .m_hash_size_o(m_hash_size_o),
        .m_hash_valid_o(m_hash_valid_o), .m_hash_ready_i(m_hash_ready_i),
        .core_state_i(core_st), .core_trg_o(core_trg_o), .core_block_o(core_block_o),
        .core_block_size_o(core_block_size_o), .core_hash_size_o(core_hash_size_o),
        .core_hash_i(core_h), .error_o(error_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Toy compression function used by the core model and by the expected-result side.
    function automatic logic [511:0] mix(input logic [511:0] h, input logic [511:0] blk,
                                         input logic [6:0] sz, input logic hs);
        return {h[446:0], h[511:447]} ^ blk ^ {505'b0, sz} ^ (hs ? 512'h5a5a : 512'h0);
    endfunction

    logic [7:0]   msg[$];
    logic [511:0] q_blk[$];
    logic [6:0]   q_sz[$];
    logic         q_hs[$];
    logic [511:0] q_hash[$];
    logic         q_hhs[$];

    int  busy_left;
    logic [6:0] core_sz;
    bit  stuck = 0;
    int  n_disp = 0;
    bit  seen_rdy_busy = 0;
    int  n_vld_pulse = 0;
    logic vld_q = 1'b0;

    // Behavioural core: trg in CLEAR/READY starts a block, trg in DONE releases back to CLEAR.
    always @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_st   <= CLEAR;
            core_h    <= IV;
            core_sz   <= '0;
            busy_left <= 0;
        end else begin
            if (core_st == BUSY && s_ready_o) seen_rdy_busy = 1;
            case (core_st)
                CLEAR, READY: begin
                    if (core_trg_o) begin
                        n_disp = n_disp + 1;
                        if (q_blk.size() == 0) begin
                            check("disp_extra", 512'd1, 512'd0);
                        end else begin
                            check("blk", core_block_o, q_blk.pop_front());
                            check("bsz", 512'(core_block_size_o), 512'(q_sz.pop_front()));
                            check("bhs", 512'(core_hash_size_o), 512'(q_hs.pop_front()));
                        end
                        core_h    <= mix(core_h, core_block_o, core_block_size_o, core_hash_size_o);
                        core_sz   <= core_block_size_o;
                        busy_left <= int'($urandom_range(1, 6));
                        core_st   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!stuck) begin
                        if (busy_left == 0) core_st <= (core_sz < 7'd64) ? DONE : READY;
                        else busy_left <= busy_left - 1;
                    end
                end
                DONE: begin
                    if (core_trg_o) begin
                        core_st <= CLEAR;
                        core_h  <= IV;
                    end
                end
                default: core_st <= CLEAR;
            endcase
        end
    end

    always @(negedge clk_i) begin
        vld_q <= m_hash_valid_o;
        if (m_hash_valid_o && !vld_q) n_vld_pulse = n_vld_pulse + 1;
    end

    task automatic fill_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Pushes the expected block sequence for msg[0..n-1]; returns the expected final hash.
    task automatic push_exp(input int n, input bit hs, output logic [511:0] h, output int nb);
        logic [511:0] blk;
        int sz;
        h  = IV;
        nb = n / 64 + 1;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            sz  = (n - 64*b > 64) ? 64 : n - 64*b;
            for (int i = 0; i < sz; i++) blk[8*i +: 8] = msg[64*b + i];
            q_blk.push_back(blk);
            q_sz.push_back(7'(sz));
            q_hs.push_back(hs);
            h = mix(h, blk, 7'(sz), hs);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nbytes,
                             input bit hs, input string tag);
        int to;
        s_data_i = d; s_last_i = last; s_bytes_i = nbytes; s_hash_size_i = hs;
        s_valid_i = 1'b1;
        to = 0;
        while (!s_ready_o && to < 500) begin
            @(negedge clk_i);
            to++;
        end
        if (!s_ready_o) check({tag, "_rdy_timeout"}, 512'd0, 512'd1);
        else @(negedge clk_i);
        s_valid_i = 1'b0;
    endtask

    // Garbage goes into bytes beyond the message, into s_bytes of non-last words and into the
    // hash-size bit after the first word, none of which may influence the result.
    task automatic drive_words(input int n, input bit hs, input int limit, input string tag);
        int nw;
        logic [63:0] w;
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int wi = 0; wi < nw && wi < limit; wi++) begin
            for (int j = 0; j < 8; j++)
                w[8*j +: 8] = (8*wi + j < n) ? msg[8*wi + j] : 8'($urandom);
            send_word(w, wi == nw - 1, (wi == nw - 1) ? 4'(n - 8*wi) : 4'($urandom),
                      (wi == 0) ? hs : ~hs, tag);
        end
    endtask

    task automatic flush_q();
        q_blk.delete(); q_sz.delete(); q_hs.delete(); q_hash.delete(); q_hhs.delete();
    endtask

    task automatic run_msg(input int n, input bit hs, input int hold, input string tag);
        logic [511:0] h, seen;
        int nb, to;
        bit held;
        push_exp(n, hs, h, nb);
        q_hash.push_back(h);
        q_hhs.push_back(hs);
        n_disp = 0; n_vld_pulse = 0; seen_rdy_busy = 0;
        drive_words(n, hs, 1000, tag);
        to = 0;
        while (!m_hash_valid_o && to < 2000) begin
            @(negedge clk_i);
            to++;
        end
        if (!m_hash_valid_o) begin
            check({tag, "_vld_timeout"}, 512'd0, 512'd1);
            flush_q();
            return;
        end
        check({tag, "_hash"}, m_hash_o, q_hash.pop_front());
        check({tag, "_hsz"}, 512'(m_hash_size_o), 512'(q_hhs.pop_front()));
        seen = m_hash_o;
        if (hold > 0) begin
            // Offer a word while the result is pending; it must not be taken.
            s_data_i = 64'hdead_beef_0bad_f00d; s_last_i = 1'b1; s_bytes_i = 4'd8;
            s_valid_i = 1'b1;
            held = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk_i);
                if (!(m_hash_valid_o && m_hash_o == seen)) held = 0;
            end
            s_valid_i = 1'b0;
            check({tag, "_held"}, 512'(held), 512'd1);
            check({tag, "_core_clear"}, 512'(core_st), 512'(CLEAR));
            check({tag, "_rdy_blocked"}, 512'(s_ready_o), 512'd0);
        end
        m_hash_ready_i = 1'b1;
        @(negedge clk_i);
        m_hash_ready_i = 1'b0;
        check({tag, "_vld_drop"}, 512'(m_hash_valid_o), 512'd0);
        check({tag, "_ndisp"}, 512'(n_disp), 512'(nb));
        check({tag, "_npulse"}, 512'(n_vld_pulse), 512'd1);
    endtask

    initial begin
        logic [511:0] h;
        int nb, to, c;
        repeat (3) @(negedge clk_i);
        check("rst_rdy", 512'(s_ready_o), 512'd0);
        check("rst_trg", 512'(core_trg_o), 512'd0);
        check("rst_blk", core_block_o, 512'd0);
        check("rst_vld", 512'(m_hash_valid_o), 512'd0);
        check("rst_err", 512'(error_o), 512'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        msg.delete();
        run_msg(0, 1'b0, 0, "empty");
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(3, 1'b1, 0, "abc");
        fill_rand(64);
        run_msg(64, 1'b0, 0, "m64");
        fill_rand(72);
        run_msg(72, 1'b1, 0, "m72");
        check("m72_rdy_while_busy", 512'(seen_rdy_busy), 512'd1);
        fill_rand(20);
        run_msg(20, 1'b0, 10, "hold");
        fill_rand(130); run_msg(130, 1'b1, 2, "m130");
        fill_rand(56);  run_msg(56, 1'b0, 1, "m56");
        fill_rand(128); run_msg(128, 1'b1, 0, "m128");
        fill_rand(7);   run_msg(7, 1'b0, 3, "m7");

        // Watchdog: core never leaves BUSY.
        stuck = 1;
        n_disp = 0;
        fill_rand(10);
        push_exp(10, 1'b0, h, nb);
        drive_words(10, 1'b0, 1000, "stuck");
        to = 0;
        while (n_disp == 0 && to < 200) begin @(negedge clk_i); to++; end
        while (core_trg_o && to < 200) begin @(negedge clk_i); to++; end
        c = 0;
        while (!error_o && c < 100) begin @(negedge clk_i); c++; end
        check("wd_err", 512'(error_o), 512'd1);
        check("wd_window", 512'(c >= TO && c <= TO + 1), 512'd1);
        check("wd_trg", 512'(core_trg_o), 512'd0);
        check("wd_rdy", 512'(s_ready_o), 512'd0);
        repeat (5) @(negedge clk_i);
        check("wd_sticky", 512'(error_o), 512'd1);

        rst_i = 1'b1;
        stuck = 0;
        flush_q();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_err", 512'(error_o), 512'd0);

        // Reset in the middle of filling a block.
        fill_rand(30);
        for (int i = 0; i < 16; i++) msg[i] = 8'h5a;
        drive_words(30, 1'b1, 2, "midfill");
        check("midfill_blk_nz", 512'(core_block_o != '0), 512'd1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_rdy", 512'(s_ready_o), 512'd0);
        check("midrst_blk", core_block_o, 512'd0);
        check("midrst_sz", 512'(core_block_size_o), 512'd0);
        check("midrst_hs", 512'(core_hash_size_o), 512'd0);
        check("midrst_trg", 512'(core_trg_o), 512'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        fill_rand(40);
        run_msg(40, 1'b1, 0, "recover");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
